dmem_responder: RTL

- Memory-side responder for the hart's data memory port (addr / ren / wen / wdata / mask / rdata).
- Replaces the combinational single-cycle dmem model with a realistic memory that has a configurable latency and a completion handshake.
- Holds a word-addressed storage array, applies byte-lane masks on writes and zeroes unmasked lanes on reads.
- Sits between the memory stage of the hart and the testbench / system.

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder with configurable latency and completion strobe
//
// Word-addressed storage behind the hart's data memory port. A request is
// accepted in IDLE or RESP, the access is performed LATENCY cycles later and
// completion is signalled by a one-cycle o_dmem_valid strobe.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_dmem_addr   request byte address (bits [1:0] ignored)
//   i_dmem_ren    read request
//   i_dmem_wen    write request
//   i_dmem_wdata  write data, already lane-shifted
//   i_dmem_mask   byte-lane enables, bit n = byte n
//   o_dmem_rdata  read data, unmasked lanes zero; zero outside RESP
//   o_dmem_busy   request outstanding, new requests ignored
//   o_dmem_valid  one-cycle completion strobe
//   o_dmem_err    error qualifier, only meaningful with o_dmem_valid
module dmem_responder #(
  parameter int unsigned  DEPTH_WORDS = 1024,
  parameter logic [31:0]  BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned  LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_busy,
  output logic        o_dmem_valid,
  output logic        o_dmem_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        perform;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_mask;
  logic        acc_ren;
  logic        acc_wen;
  logic [31:0] word;
  logic [AW-1:0] widx;
  logic        oor;
  logic        acc_err;
  logic        mem_we;
  logic [31:0] rd_word;

  assign accept = (state_q != ST_WAIT) && (i_dmem_ren || i_dmem_wen);

  // With a single-cycle latency the access happens on the accepting edge,
  // so the operands come straight from the port instead of the capture regs.
  assign perform = i_rst_n &&
                   ((LATENCY == 1) ? accept
                                   : ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

  assign acc_addr  = (LATENCY == 1) ? i_dmem_addr  : addr_q;
  assign acc_wdata = (LATENCY == 1) ? i_dmem_wdata : wdata_q;
  assign acc_mask  = (LATENCY == 1) ? i_dmem_mask  : mask_q;
  assign acc_ren   = (LATENCY == 1) ? i_dmem_ren   : ren_q;
  assign acc_wen   = (LATENCY == 1) ? i_dmem_wen   : wen_q;

  // Addresses below BASE_ADDR wrap to huge indices and fall out of range.
  assign word    = (acc_addr - BASE_ADDR) >> 2;
  assign oor     = (word >= 32'(DEPTH_WORDS));
  assign widx    = word[AW-1:0];
  assign acc_err = (acc_ren && acc_wen) || oor;
  assign mem_we  = perform && acc_wen && !acc_err;
  assign rd_word = oor ? 32'h0 : mem[widx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    rdata_d = 32'h0;
    err_d   = 1'b0;

    if (accept) begin
      addr_d  = i_dmem_addr;
      wdata_d = i_dmem_wdata;
      mask_d  = i_dmem_mask;
      ren_d   = i_dmem_ren;
      wen_d   = i_dmem_wen;
      cnt_d   = 4'(LATENCY - 1);
      state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RESP;
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Response data is only loaded on the edge entering RESP; every other
    // edge clears it so rdata/err read as zero outside the strobe cycle.
    if (perform) begin
      err_d = acc_err;
      if (!acc_err && acc_ren) begin
        for (int b = 0; b < 4; b++) begin
          rdata_d[8*b +: 8] = acc_mask[b] ? rd_word[8*b +: 8] : 8'h00;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem[widx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign o_dmem_busy  = (state_q == ST_WAIT);
  assign o_dmem_valid = (state_q == ST_RESP);
  assign o_dmem_rdata = rdata_q;
  assign o_dmem_err   = err_q;

endmodule
